// File: rtl/clz64_pkg.sv
// clz64_pkg: shared constants, types and the segment-merge helper for the
// 64-bit count-leading-zeros unit.
//   CLZ64_W / CLZ64_CNT_W : operand width and result width (0..64 needs 7 bits)
//   CLZ16_W / CLZ16_CNT_W : leaf segment width and leaf count width (0..16)
// Segment k of the operand is counted from the MSB: segment 0 is bits 63:48.
package clz64_pkg;

  localparam int CLZ64_W     = 64;
  localparam int CLZ64_CNT_W = 7;
  localparam int CLZ16_W     = 16;
  localparam int CLZ16_CNT_W = 5;
  localparam int CLZ64_SEGS  = CLZ64_W / CLZ16_W;

  typedef logic [CLZ64_W-1:0]     clz64_word_t;
  typedef logic [CLZ64_CNT_W-1:0] clz64_cnt_t;
  typedef logic [CLZ16_CNT_W-1:0] clz16_cnt_t;

  typedef logic [CLZ64_SEGS-1:0][CLZ16_CNT_W-1:0] leaf_cnt_vec_t;
  typedef logic [CLZ64_SEGS-1:0]                  leaf_zero_vec_t;

  // Pick the first non-zero segment from the MSB side and add its leaf count
  // to 16*k. Iterating from the LSB segment upward lets the MSB-most non-zero
  // segment overwrite any earlier choice. All-zero falls through to 64.
  function automatic clz64_cnt_t clz64_merge(input leaf_cnt_vec_t  cnt,
                                             input leaf_zero_vec_t zero);
    clz64_cnt_t res;
    res = clz64_cnt_t'(CLZ64_W);
    for (int k = CLZ64_SEGS - 1; k >= 0; k--) begin
      if (!zero[k]) begin
        res = clz64_cnt_t'(k * CLZ16_W) + clz64_cnt_t'(cnt[k]);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/clz16.sv
// clz16: purely combinational 16-bit count-leading-zeros leaf.
//   seg_i  [15:0] : segment, bit 15 is its MSB
//   cnt_o  [4:0]  : leading-zero count 0..16 (16 when the segment is zero)
//   zero_o        : segment is all zeros
module clz16
  import clz64_pkg::*;
(
  input  logic [CLZ16_W-1:0] seg_i,
  output clz16_cnt_t         cnt_o,
  output logic               zero_o
);

  // Ascending scan: the last assignment wins, i.e. the highest set bit.
  always_comb begin
    cnt_o = clz16_cnt_t'(CLZ16_W);
    for (int b = 0; b < CLZ16_W; b++) begin
      if (seg_i[b]) begin
        cnt_o = clz16_cnt_t'(CLZ16_W - 1 - b);
      end
    end
  end

  assign zero_o = ~|seg_i;

endmodule

// File: rtl/clz64_pipelined.sv
// clz64_pipelined: registered 64-bit count-leading-zeros unit.
//   i_CLK        : clock, rising edge
//   i_RST        : asynchronous active-high reset, clears every flop
//   i_VALID      : i_WORD valid this cycle
//   i_WORD [63:0]: operand, bit 63 is the MSB
//   o_VALID      : o_COUNT / o_ZERO valid this cycle
//   o_COUNT [6:0]: leading-zero count, 0..64
//   o_ZERO       : operand was all zeros
// Build option: define CLZ64_PIPE_EN to register the four leaf results
// between the leaves and the merge, giving a 2-cycle latency instead of 1.
// Data flops load only on valid, so o_COUNT/o_ZERO hold across gaps.
module clz64_pipelined
  import clz64_pkg::*;
(
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_VALID,
  input  clz64_word_t i_WORD,
  output logic        o_VALID,
  output clz64_cnt_t  o_COUNT,
  output logic        o_ZERO
);

  leaf_cnt_vec_t  leaf_cnt;
  leaf_zero_vec_t leaf_zero;

  // Leaf gi sees segment gi counted from the MSB.
  generate
    for (genvar gi = 0; gi < CLZ64_SEGS; gi++) begin : g_leaf
      clz16 u_clz16 (
        .seg_i  (i_WORD[CLZ64_W-1-gi*CLZ16_W -: CLZ16_W]),
        .cnt_o  (leaf_cnt[gi]),
        .zero_o (leaf_zero[gi])
      );
    end
  endgenerate

  // Inputs to the merge stage, either straight from the leaves or from the
  // optional intermediate register.
  logic           merge_valid;
  leaf_cnt_vec_t  merge_cnt;
  leaf_zero_vec_t merge_zero;

`ifdef CLZ64_PIPE_EN
  logic           s1_valid_q;
  leaf_cnt_vec_t  s1_cnt_q;
  leaf_zero_vec_t s1_zero_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      s1_valid_q <= 1'b0;
      s1_cnt_q   <= '0;
      s1_zero_q  <= '0;
    end else begin
      s1_valid_q <= i_VALID;
      if (i_VALID) begin
        s1_cnt_q  <= leaf_cnt;
        s1_zero_q <= leaf_zero;
      end
    end
  end

  assign merge_valid = s1_valid_q;
  assign merge_cnt   = s1_cnt_q;
  assign merge_zero  = s1_zero_q;
`else
  assign merge_valid = i_VALID;
  assign merge_cnt   = leaf_cnt;
  assign merge_zero  = leaf_zero;
`endif

  clz64_cnt_t count_d;
  logic       zero_d;

  assign count_d = clz64_merge(merge_cnt, merge_zero);
  assign zero_d  = &merge_zero;

  logic       valid_q;
  clz64_cnt_t count_q;
  logic       zero_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      valid_q <= 1'b0;
      count_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= merge_valid;
      if (merge_valid) begin
        count_q <= count_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign o_VALID = valid_q;
  assign o_COUNT = count_q;
  assign o_ZERO  = zero_q;

endmodule

// File: tb/tb_clz64_pipelined.sv
// tb_clz64_pipelined: randomized and directed checks of clz64_pipelined
// against a behavioural model (delay line of input samples + "63 minus index
// of highest set bit" reference). Latency follows CLZ64_PIPE_EN.
module tb_clz64_pipelined;

`ifdef CLZ64_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic [63:0] word_in;
  logic        valid_out;
  logic [6:0]  count_out;
  logic        zero_out;

  clz64_pipelined dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_VALID (valid_in),
    .i_WORD  (word_in),
    .o_VALID (valid_out),
    .o_COUNT (count_out),
    .o_ZERO  (zero_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: inputs sampled at the last L edges, plus held outputs.
  logic        mv [0:L-1];
  logic [63:0] mw [0:L-1];
  logic        exp_v;
  int          exp_cnt;
  logic        exp_zero;

  function automatic int ref_clz(input logic [63:0] w);
    for (int b = 63; b >= 0; b--) begin
      if (w[b]) return 63 - b;
    end
    return 64;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < L; i++) begin
      mv[i] = 1'b0;
      mw[i] = '0;
    end
    exp_v    = 1'b0;
    exp_cnt  = 0;
    exp_zero = 1'b0;
  endtask

  task automatic check_model(input string tag);
    cmp({tag, ".valid"}, int'(valid_out), int'(exp_v));
    cmp({tag, ".count"}, int'(count_out), exp_cnt);
    cmp({tag, ".zero"},  int'(zero_out),  int'(exp_zero));
  endtask

  // Present one input, clock it, advance the model and compare 1ns later.
  task automatic step(input logic v, input logic [63:0] w, input string tag);
    valid_in = v;
    word_in  = w;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      for (int i = L - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mw[i] = mw[i-1];
      end
      mv[0] = v;
      mw[0] = w;
      exp_v = mv[L-1];
      if (mv[L-1]) begin
        exp_cnt  = ref_clz(mw[L-1]);
        exp_zero = (mw[L-1] == 64'h0);
      end
    end
    #1;
    check_model(tag);
  endtask

  // Clock idle cycles until a word issued by the previous step reaches the output.
  task automatic drain(input string tag);
    for (int i = 1; i < L; i++) step(1'b0, 64'h0, tag);
  endtask

  initial begin
    rst      = 1'b1;
    valid_in = 1'b0;
    word_in  = '0;
    model_clear();

    // 1. Reset with no clock edge yet.
    #1;
    cmp("reset.valid", int'(valid_out), 0);
    cmp("reset.count", int'(count_out), 0);
    cmp("reset.zero",  int'(zero_out),  0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "in_reset");
    step(1'b0, 64'h0, "in_reset");
    rst = 1'b0;

    // 2. Mixed word, bit 32 is the highest set bit.
    step(1'b1, 64'h0000_0001_AA80_A208, "t2");
    drain("t2");
    cmp("t2.lit_valid", int'(valid_out), 1);
    cmp("t2.lit_count", int'(count_out), 31);
    cmp("t2.lit_zero",  int'(zero_out),  0);

    // 3. Boundaries: all-zero and MSB set.
    step(1'b1, 64'h0, "t3z");
    drain("t3z");
    cmp("t3z.lit_count", int'(count_out), 64);
    cmp("t3z.lit_zero",  int'(zero_out),  1);
    step(1'b1, 64'h8000_0000_0000_0000, "t3m");
    drain("t3m");
    cmp("t3m.lit_count", int'(count_out), 0);
    cmp("t3m.lit_zero",  int'(zero_out),  0);

    // 4. Walking one, back to back.
    for (int i = 0; i < 64; i++) begin
      logic [63:0] w;
      w = 64'h1 << i;
      step(1'b1, w, "walk");
    end
    drain("walk");
    cmp("walk.lit_count", int'(count_out), 0);

    // 5. Valid, gap, valid.
    step(1'b1, 64'h1, "t5a");
    step(1'b0, 64'hDEAD_BEEF_0000_0000, "t5gap");
    step(1'b1, 64'h0000_8000_0000_0000, "t5b");
    drain("t5b");
    cmp("t5.lit_count", int'(count_out), 16);

    // 6. Reset with a word in flight: it must never emerge.
    step(1'b1, 64'h0000_0000_0000_00F0, "t6");
    #2;
    rst = 1'b1;
    #1;
    model_clear();
    cmp("t6.rst_valid", int'(valid_out), 0);
    cmp("t6.rst_count", int'(count_out), 0);
    step(1'b0, 64'h0, "t6_in_reset");
    rst = 1'b0;
    for (int i = 0; i < L + 1; i++) step(1'b0, 64'h0, "t6_after");

    // Randomized stream: random valid, random leading-zero depth.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] w;
      logic        v;
      w = {$urandom, $urandom};
      w = w >> $urandom_range(0, 64);
      v = ($urandom_range(0, 3) != 0);
      step(v, w, "rand");
    end
    drain("rand_tail");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
